// File: rtl/spi_result_responder_pkg.sv
`default_nettype none
// ============================================================================
//  spi_result_pkg
//  Shared constants and register-map helper for the SPI result responder.
//  Revision: 1.0
// ============================================================================
package spi_result_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [3:0] OP_READ         = 4'h6;
    localparam logic [3:0] RESULT_BASE     = 4'd8;
    localparam logic [7:0] CMD_READ_RESULT = 8'h68;

    // Result occupies six consecutive addresses, most significant byte first.
    function automatic logic [7:0] map_byte(
        input logic [3:0]  addr,
        input logic [7:0]  id,
        input logic [47:0] snap
    );
        logic [7:0] v;
        v = 8'h00;
        case (addr)
            4'd0:               v = id;
            RESULT_BASE + 4'd0: v = snap[47:40];
            RESULT_BASE + 4'd1: v = snap[39:32];
            RESULT_BASE + 4'd2: v = snap[31:24];
            RESULT_BASE + 4'd3: v = snap[23:16];
            RESULT_BASE + 4'd4: v = snap[15:8];
            RESULT_BASE + 4'd5: v = snap[7:0];
            default:            v = 8'h00;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_result_responder_if.sv
`default_nettype none
// ============================================================================
//  spi_result_responder_if
//  SPI pin bundle between master and result responder (slave).
//  Revision: 1.0
// ============================================================================
interface spi_result_responder_if;
    logic spi_clk;
    logic cs_n;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_clk, output cs_n, output spi_mosi, input  spi_miso);
    modport slave  (input  spi_clk, input  cs_n, input  spi_mosi, output spi_miso);
endinterface
`default_nettype wire

// File: rtl/spi_result_responder_sync.sv
`default_nettype none
// ============================================================================
//  spi_pin_sync
//  Two-flop synchronizer with registered rise/fall strobes for one SPI pin.
//  Revision: 1.0
// ============================================================================
module spi_pin_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic aresetn,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge i_clk or negedge aresetn) begin
        if (!aresetn) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= i_pin;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;

endmodule
`default_nettype wire

// File: rtl/spi_result_responder.sv
`default_nettype none
// ============================================================================
//  spi_result_responder
//  SPI mode-1 slave serving a 16-byte map holding the latest 48-bit result.
//  Revision: 1.0
// ============================================================================
module spi_result_responder
    import spi_result_pkg::*;
#(
    parameter logic [7:0] ID_BYTE = 8'hA5
) (
    input  logic                         i_clk,
    input  logic                         aresetn,
    spi_result_responder_if.slave        spi,
    output logic                         o_intr_n,
    input  logic [47:0]                  i_result,
    input  logic                         i_result_valid,
    output logic                         o_busy,
    output logic                         o_cmd_tick,
    output logic [7:0]                   o_cmd,
    output logic                         o_byte_tick
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_pin_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
        .i_clk   (i_clk),
        .aresetn (aresetn),
        .i_pin   (spi.spi_clk),
        .o_rise  (sclk_rise),
        .o_fall  (sclk_fall)
    );

    spi_pin_sync #(.RESET_VAL(1'b1)) u_cs_sync (
        .i_clk   (i_clk),
        .aresetn (aresetn),
        .i_pin   (spi.cs_n),
        .o_rise  (cs_rise),
        .o_fall  (cs_fall)
    );

    logic        mosi_meta_q, mosi_q;
    logic [1:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  cmd_sr_q, cmd_sr_d;
    logic [7:0]  tx_sr_q, tx_sr_d;
    logic        miso_q, miso_d;
    logic [3:0]  addr_q, addr_d;
    logic        read_q, read_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        cmd_tick_q, cmd_tick_d;
    logic        byte_tick_q, byte_tick_d;
    logic [47:0] snap_q, snap_d;
    logic [47:0] pend_val_q, pend_val_d;
    logic        pend_q, pend_d;
    logic        intr_n_q, intr_n_d;
    logic [7:0]  w_cmd_byte;
    logic [3:0]  w_next_addr;

    assign w_cmd_byte  = {cmd_sr_q, mosi_q};
    assign w_next_addr = addr_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_sr_d    = cmd_sr_q;
        tx_sr_d     = tx_sr_q;
        miso_d      = miso_q;
        addr_d      = addr_q;
        read_d      = read_q;
        cmd_d       = cmd_q;
        cmd_tick_d  = 1'b0;
        byte_tick_d = 1'b0;
        snap_d      = snap_q;
        pend_val_d  = pend_val_q;
        pend_d      = pend_q;
        intr_n_d    = intr_n_q;

        if (cs_rise) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd7;
                        tx_sr_d   = 8'h00;
                    end
                end
                ST_CMD, ST_DATA: begin
                    if (sclk_rise) begin
                        miso_d  = tx_sr_q[7];
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                    if (sclk_fall) begin
                        cmd_sr_d  = w_cmd_byte[6:0];
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            bit_cnt_d = 3'd7;
                            if (state_q == ST_CMD) begin
                                state_d    = ST_DATA;
                                cmd_d      = w_cmd_byte;
                                cmd_tick_d = 1'b1;
                                if (w_cmd_byte[7:4] == OP_READ) begin
                                    read_d   = 1'b1;
                                    addr_d   = w_cmd_byte[3:0];
                                    tx_sr_d  = map_byte(w_cmd_byte[3:0], ID_BYTE, snap_q);
                                    intr_n_d = 1'b1;
                                end else begin
                                    read_d  = 1'b0;
                                    tx_sr_d = 8'hFF;
                                end
                            end else begin
                                byte_tick_d = 1'b1;
                                if (read_q) begin
                                    addr_d  = w_next_addr;
                                    tx_sr_d = map_byte(w_next_addr, ID_BYTE, snap_q);
                                end else begin
                                    tx_sr_d = 8'hFF;
                                end
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Snapshot only changes in IDLE; anything arriving mid-burst is parked.
        if (state_q == ST_IDLE) begin
            if (i_result_valid) begin
                snap_d   = i_result;
                intr_n_d = 1'b0;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                snap_d   = pend_val_q;
                intr_n_d = 1'b0;
                pend_d   = 1'b0;
            end
        end else if (i_result_valid) begin
            pend_val_d = i_result;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge aresetn) begin
        if (!aresetn) begin
            mosi_meta_q <= 1'b0;
            mosi_q      <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd7;
            cmd_sr_q    <= 7'd0;
            tx_sr_q     <= 8'h00;
            miso_q      <= 1'b0;
            addr_q      <= 4'd0;
            read_q      <= 1'b0;
            cmd_q       <= 8'h00;
            cmd_tick_q  <= 1'b0;
            byte_tick_q <= 1'b0;
            snap_q      <= 48'd0;
            pend_val_q  <= 48'd0;
            pend_q      <= 1'b0;
            intr_n_q    <= 1'b1;
        end else begin
            mosi_meta_q <= spi.spi_mosi;
            mosi_q      <= mosi_meta_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            tx_sr_q     <= tx_sr_d;
            miso_q      <= miso_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            cmd_q       <= cmd_d;
            cmd_tick_q  <= cmd_tick_d;
            byte_tick_q <= byte_tick_d;
            snap_q      <= snap_d;
            pend_val_q  <= pend_val_d;
            pend_q      <= pend_d;
            intr_n_q    <= intr_n_d;
        end
    end

    assign spi.spi_miso = miso_q;
    assign o_intr_n     = intr_n_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_cmd_tick   = cmd_tick_q;
    assign o_cmd        = cmd_q;
    assign o_byte_tick  = byte_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_result_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  tb_spi_result_responder
//  Self-checking bench: directed table, corner sequences, randomized bursts.
//  Revision: 1.0
// ============================================================================
module tb_spi_result_responder;
    import spi_result_pkg::*;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        o_intr_n, o_busy, o_cmd_tick, o_byte_tick;
    logic [7:0]  o_cmd;
    logic [47:0] i_result = '0;
    logic        i_result_valid = 1'b0;

    always #5 clk = ~clk;

    spi_result_responder_if spi_if();

    spi_result_responder #(.ID_BYTE(8'hA5)) dut (
        .i_clk          (clk),
        .aresetn        (aresetn),
        .spi            (spi_if.slave),
        .o_intr_n       (o_intr_n),
        .i_result       (i_result),
        .i_result_valid (i_result_valid),
        .o_busy         (o_busy),
        .o_cmd_tick     (o_cmd_tick),
        .o_cmd          (o_cmd),
        .o_byte_tick    (o_byte_tick)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cmd_ticks = 0;
    int byte_ticks = 0;
    logic [7:0] rx_buf [0:6];

    always @(negedge clk) begin
        if (o_cmd_tick)  cmd_ticks++;
        if (o_byte_tick) byte_ticks++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [47:0] v);
        i_result       = v;
        i_result_valid = 1'b1;
        cyc(1);
        i_result_valid = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            spi_if.spi_clk  = 1'b1;
            spi_if.spi_mosi = tx[7-b];
            cyc(HALF);
            rx = {rx[6:0], spi_if.spi_miso};
            spi_if.spi_clk = 1'b0;
            cyc(HALF);
        end
    endtask

    // Full burst: command + nbytes dummies; optional result strobe inside byte strobe_at.
    task automatic xfer(input logic [7:0] cmd, input int nbytes, input int strobe_at, input logic [47:0] sv);
        logic [7:0] r;
        spi_if.cs_n = 1'b0;
        cyc(HALF);
        for (int k = 0; k <= nbytes; k++) begin
            if (k == strobe_at) begin
                fork
                    spi_bits((k == 0) ? cmd : 8'h00, 8, r);
                    begin cyc(20); pulse(sv); end
                join
            end else begin
                spi_bits((k == 0) ? cmd : 8'h00, 8, r);
            end
            rx_buf[k] = r;
        end
        spi_if.cs_n = 1'b1;
        cyc(10);
    endtask

    // Reference register map built from the snapshot value.
    function automatic logic [7:0] m_read(input int a, input logic [47:0] s);
        logic [7:0] mem [16];
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5;
        for (int i = 0; i < 6; i++) mem[8+i] = s[47-8*i -: 8];
        return mem[a % 16];
    endfunction

    typedef struct {
        bit          do_load;
        logic [47:0] load;
        logic [7:0]  cmd;
        int          nbytes;
        logic [55:0] exp;
        logic        exp_intr;
    } vec_t;

    vec_t vt [5];

    initial begin
        logic [7:0]  r;
        logic [47:0] m_snap;
        logic        m_intr_n;
        logic [63:0] r64;
        logic [7:0]  cmd;
        logic [7:0]  expb [0:6];
        logic [47:0] v, sv;
        int          c0, b0, n, sat, waited;

        vt[0] = '{1'b1, 48'h0123_4567_89AB, 8'h68, 6, 56'h00_01_23_45_67_89_AB, 1'b1};
        vt[1] = '{1'b0, 48'h0,              8'h6F, 3, 56'h00_00_A5_00_00_00_00, 1'b1};
        vt[2] = '{1'b1, 48'hA1B2_C3D4_E5F6, 8'h12, 3, 56'h00_FF_FF_FF_00_00_00, 1'b0};
        vt[3] = '{1'b0, 48'h0,              8'h6C, 2, 56'h00_E5_F6_00_00_00_00, 1'b1};
        vt[4] = '{1'b0, 48'h0,              8'h60, 2, 56'h00_A5_00_00_00_00_00, 1'b1};

        spi_if.spi_clk  = 1'b0;
        spi_if.cs_n     = 1'b1;
        spi_if.spi_mosi = 1'b0;
        cyc(3);
        check("rst_miso", spi_if.spi_miso, 0);
        check("rst_intr_n", o_intr_n, 1);
        check("rst_busy", o_busy, 0);
        check("rst_cmd", o_cmd, 0);
        check("rst_ticks", {o_cmd_tick, o_byte_tick}, 0);
        aresetn = 1'b1;
        cyc(3);

        // Directed table
        for (int t = 0; t < 5; t++) begin
            if (vt[t].do_load) begin
                pulse(vt[t].load);
                cyc(2);
                check("load_intr_low", o_intr_n, 0);
            end
            c0 = cmd_ticks; b0 = byte_ticks;
            xfer(vt[t].cmd, vt[t].nbytes, -1, 48'h0);
            for (int i = 0; i <= vt[t].nbytes; i++)
                check($sformatf("tbl%0d_byte%0d", t, i), rx_buf[i], vt[t].exp[55-8*i -: 8]);
            check($sformatf("tbl%0d_cmd", t), o_cmd, vt[t].cmd);
            check($sformatf("tbl%0d_cmd_ticks", t), cmd_ticks - c0, 1);
            check($sformatf("tbl%0d_byte_ticks", t), byte_ticks - b0, vt[t].nbytes);
            check($sformatf("tbl%0d_intr_n", t), o_intr_n, vt[t].exp_intr);
            check($sformatf("tbl%0d_busy", t), o_busy, 0);
        end

        // Result strobe in the middle of a burst is deferred until cs_n rises
        pulse(48'h0123_4567_89AB);
        cyc(2);
        xfer(8'h68, 6, 3, 48'hFFFF_0000_1111);
        expb = '{8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
        for (int i = 0; i < 7; i++) check($sformatf("mid_byte%0d", i), rx_buf[i], expb[i]);
        check("mid_intr_after", o_intr_n, 0);
        xfer(8'h68, 6, -1, 48'h0);
        expb = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h11, 8'h11};
        for (int i = 0; i < 7; i++) check($sformatf("mid_next%0d", i), rx_buf[i], expb[i]);

        // Abort after four bits of the second data byte
        c0 = cmd_ticks; b0 = byte_ticks;
        spi_if.cs_n = 1'b0;
        cyc(HALF);
        spi_bits(8'h68, 8, r);
        spi_bits(8'h00, 8, r);
        check("abort_byte1", r, 8'hFF);
        spi_bits(8'h00, 4, r);
        spi_if.cs_n = 1'b1;
        waited = 0;
        while (o_busy && waited < 8) begin cyc(1); waited++; end
        check("abort_busy_within4", (waited <= 4), 1);
        cyc(4);
        check("abort_byte_ticks", byte_ticks - b0, 1);
        check("abort_cmd_ticks", cmd_ticks - c0, 1);
        check("abort_miso", spi_if.spi_miso, 0);
        xfer(8'h6A, 4, -1, 48'h0);
        expb = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h11, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) check($sformatf("abort_next%0d", i), rx_buf[i], expb[i]);

        // Reset mid-DATA, with a pending result that must be discarded
        spi_if.cs_n = 1'b0;
        cyc(HALF);
        spi_bits(8'h68, 8, r);
        spi_bits(8'h00, 8, r);
        pulse(48'h1234_5678_9ABC);
        spi_bits(8'h00, 3, r);
        aresetn = 1'b0;
        spi_if.cs_n = 1'b1;
        #1;
        check("mrst_miso", spi_if.spi_miso, 0);
        check("mrst_intr_n", o_intr_n, 1);
        check("mrst_busy", o_busy, 0);
        check("mrst_cmd", o_cmd, 0);
        check("mrst_ticks", {o_cmd_tick, o_byte_tick}, 0);
        cyc(3);
        aresetn = 1'b1;
        cyc(5);
        xfer(8'h68, 6, -1, 48'h0);
        for (int i = 0; i < 7; i++) check($sformatf("mrst_byte%0d", i), rx_buf[i], 8'h00);
        check("mrst_intr_after", o_intr_n, 1);

        // Randomized bursts against the reference model
        m_snap = 48'h0;
        m_intr_n = 1'b1;
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                r64 = {$urandom, $urandom};
                v = r64[47:0];
                pulse(v);
                m_snap = v;
                m_intr_n = 1'b0;
                cyc(2);
                check($sformatf("rnd%0d_load_intr", it), o_intr_n, m_intr_n);
            end
            cmd = ($urandom_range(0, 1) == 1) ? {4'h6, 4'($urandom)} : 8'($urandom);
            n = $urandom_range(1, 6);
            sat = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n) : -1;
            r64 = {$urandom, $urandom};
            sv = r64[47:0];
            expb[0] = 8'h00;
            for (int k = 1; k <= n; k++)
                expb[k] = (cmd[7:4] == 4'h6) ? m_read(int'(cmd[3:0]) + k - 1, m_snap) : 8'hFF;
            c0 = cmd_ticks; b0 = byte_ticks;
            xfer(cmd, n, sat, sv);
            if (cmd[7:4] == 4'h6) m_intr_n = 1'b1;
            if (sat >= 0) begin
                m_snap = sv;
                m_intr_n = 1'b0;
            end
            for (int k = 0; k <= n; k++)
                check($sformatf("rnd%0d_byte%0d", it, k), rx_buf[k], expb[k]);
            check($sformatf("rnd%0d_cmd", it), o_cmd, cmd);
            check($sformatf("rnd%0d_cmd_ticks", it), cmd_ticks - c0, 1);
            check($sformatf("rnd%0d_byte_ticks", it), byte_ticks - b0, n);
            check($sformatf("rnd%0d_intr_n", it), o_intr_n, m_intr_n);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
